// File: rtl/serial_host_pkg.sv
// Shared opcodes, FSM state encoding and the read-timeout fill pattern
// for the serial host controller.
package serial_host_pkg;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RUN   = 2'b11;

    // Returned to the host in place of read data when memory never acks
    localparam logic [15:0] TIMEOUT_PATTERN = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_ADDR,
        ST_DATA,
        ST_STOP,
        ST_EXEC,
        ST_RESP
    } state_t;

endpackage

// File: rtl/serial_tx_shift.sv
// Parallel-load response shifter; idles with all ones so the line rests high
// and refills with ones as the loaded word is shifted out MSB first.
module serial_tx_shift #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             so
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = {shift_q[WIDTH-2:0], 1'b1};
        if (load) begin
            shift_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '1;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign so = shift_q[WIDTH-1];

endmodule

// File: rtl/serial_host_ctrl.sv
// Serial host controller: receives command frames on si, runs memory
// accesses over a req/ack port, returns read data on so and gates cpu_run.
module serial_host_ctrl
    import serial_host_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              C,
    input  logic              RN,
    input  logic              si,
    output logic              so,
    output logic              cpu_run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              frame_err
);

    localparam int SH_W  = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(((ADDR_W > DATA_W + 2) ? ADDR_W : DATA_W + 2) + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_OPC  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ADDR = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  CNT_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_RESP = CNT_W'(DATA_W + 1);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TO_DATA  = DATA_W'(TIMEOUT_PATTERN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   tout_q, tout_d;
    logic [1:0]        op_q, op_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic              cpu_run_q, cpu_run_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              frame_err_q, frame_err_d;
    logic              tx_load;
    logic [DATA_W+1:0] tx_data;
    logic [ADDR_W-1:0] rx_addr;

    // Short frames shift only the address, so it sits in the low bits then
    assign rx_addr = (op_q == OP_WRITE) ? sh_q[SH_W-1 -: ADDR_W] : sh_q[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tout_d      = tout_q;
        op_d        = op_q;
        sh_d        = sh_q;
        cpu_run_d   = cpu_run_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        frame_err_d = 1'b0;
        tx_load     = 1'b0;
        tx_data     = {1'b0, mem_rdata, 1'b1};

        case (state_q)
            ST_IDLE: begin
                if (!si) begin
                    state_d = ST_OPC;
                    cnt_d   = CNT_OPC;
                end
            end
            ST_OPC: begin
                op_d = {op_q[0], si};
                if (cnt_q == '0) begin
                    state_d = ST_ADDR;
                    cnt_d   = CNT_ADDR;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ADDR: begin
                sh_d = {sh_q[SH_W-2:0], si};
                if (cnt_q == '0) begin
                    if (op_q == OP_WRITE) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_DATA;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                sh_d = {sh_q[SH_W-2:0], si};
                if (cnt_q == '0) begin
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
                if (!si) begin
                    frame_err_d = 1'b1;
                end else if (op_q == OP_HALT) begin
                    cpu_run_d = 1'b0;
                end else if (op_q == OP_RUN) begin
                    cpu_run_d = 1'b1;
                end else if (cpu_run_q) begin
                    frame_err_d = 1'b1;
                end else begin
                    state_d    = ST_EXEC;
                    mem_req_d  = 1'b1;
                    mem_we_d   = (op_q == OP_WRITE);
                    mem_addr_d = rx_addr;
                    tout_d     = '0;
                    if (op_q == OP_WRITE) begin
                        mem_wdata_d = sh_q[DATA_W-1:0];
                    end
                end
            end
            ST_EXEC: begin
                // Error pulse is registered so it lands after mem_req has fallen
                if (mem_ack || tout_q == TO_LAST) begin
                    mem_req_d   = 1'b0;
                    frame_err_d = !mem_ack;
                    if (mem_we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                        cnt_d   = CNT_RESP;
                        tx_load = 1'b1;
                        if (!mem_ack) begin
                            tx_data = {1'b0, TO_DATA, 1'b1};
                        end
                    end
                end else begin
                    tout_d = tout_q + TO_ONE;
                end
            end
            ST_RESP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tout_q      <= '0;
            op_q        <= '0;
            sh_q        <= '0;
            cpu_run_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tout_q      <= tout_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            cpu_run_q   <= cpu_run_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            frame_err_q <= frame_err_d;
        end
    end

    serial_tx_shift #(
        .WIDTH(DATA_W + 2)
    ) u_tx (
        .clk      (C),
        .rst_n    (RN),
        .load     (tx_load),
        .load_data(tx_data),
        .so       (so)
    );

    assign busy      = (state_q != ST_IDLE);
    assign cpu_run   = cpu_run_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_host_ctrl.sv
// Directed bench for serial_host_ctrl: frames are driven bit by bit and every
// observation is compared against hand-computed values.
module tb_serial_host_ctrl;

    logic        C;
    logic        RN;
    logic        si;
    logic        so;
    logic        cpu_run;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    int ferr_cnt = 0;
    int overlap_cnt = 0;

    serial_host_ctrl #(
        .DATA_W (16),
        .ADDR_W (8),
        .TIMEOUT(15)
    ) dut (
        .C        (C),
        .RN       (RN),
        .si       (si),
        .so       (so),
        .cpu_run  (cpu_run),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .frame_err(frame_err)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    always @(negedge C) begin
        if (mem_req === 1'b1) req_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (mem_req === 1'b1 && frame_err === 1'b1) overlap_cnt++;
    end

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives up to max_bits of a frame, one bit per clock, then idles si high
    task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] addr,
                                  input logic [15:0] data, input logic stop_bit,
                                  input int max_bits);
        logic [27:0] fr;
        int len;
        if (op == 2'b01) begin
            fr  = {1'b0, op, addr, data, stop_bit};
            len = 28;
        end else begin
            fr  = {16'hFFFF, 1'b0, op, addr, stop_bit};
            len = 12;
        end
        for (int i = 0; i < len && i < max_bits; i++) begin
            si = fr[len-1-i];
            step();
        end
        si = 1'b1;
    endtask

    task automatic collect_resp(output logic [17:0] v);
        v = '0;
        for (int i = 0; i < 18; i++) begin
            v = {v[16:0], so};
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] resp;
        int base_req;
        int n;

        RN = 1'b0;
        si = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        step();
        step();
        check_output("rst_so", {31'b0, so}, 32'h1);
        check_output("rst_busy", {31'b0, busy}, 32'h0);
        check_output("rst_req", {31'b0, mem_req}, 32'h0);
        check_output("rst_run", {31'b0, cpu_run}, 32'h0);
        check_output("rst_addr", {24'b0, mem_addr}, 32'h0);
        check_output("rst_wdata", {16'b0, mem_wdata}, 32'h0);
        check_output("rst_ferr", {31'b0, frame_err}, 32'h0);
        RN = 1'b1;
        step();
        step();

        // WRITE 3C/A55A acked in the first request cycle
        apply_stimulus(2'b01, 8'h3C, 16'hA55A, 1'b1, 28);
        check_output("wr_req", {31'b0, mem_req}, 32'h1);
        check_output("wr_we", {31'b0, mem_we}, 32'h1);
        check_output("wr_addr", {24'b0, mem_addr}, 32'h3C);
        check_output("wr_wdata", {16'b0, mem_wdata}, 32'hA55A);
        check_output("wr_busy", {31'b0, busy}, 32'h1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_output("wr_req_drop", {31'b0, mem_req}, 32'h0);
        check_output("wr_busy_low", {31'b0, busy}, 32'h0);
        step();

        // READ 05 acked three cycles after the request rises
        apply_stimulus(2'b10, 8'h05, 16'h0000, 1'b1, 12);
        check_output("rd_req", {31'b0, mem_req}, 32'h1);
        check_output("rd_we", {31'b0, mem_we}, 32'h0);
        check_output("rd_addr", {24'b0, mem_addr}, 32'h05);
        step();
        step();
        step();
        check_output("rd_so_wait", {31'b0, so}, 32'h1);
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        check_output("rd_req_drop", {31'b0, mem_req}, 32'h0);
        collect_resp(resp);
        check_output("rd_resp", {14'b0, resp}, {14'b0, 1'b0, 16'h1234, 1'b1});
        check_output("rd_so_idle", {31'b0, so}, 32'h1);
        check_output("rd_busy_end", {31'b0, busy}, 32'h0);

        // READ 07 never acked: 15 request cycles, error pulse, DEAD response
        base_req = req_cnt;
        apply_stimulus(2'b10, 8'h07, 16'h0000, 1'b1, 12);
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_output("to_req_len", n, 15);
        check_output("to_ferr", {31'b0, frame_err}, 32'h1);
        collect_resp(resp);
        check_output("to_resp", {14'b0, resp}, {14'b0, 1'b0, 16'hDEAD, 1'b1});
        check_output("to_req_cnt", req_cnt - base_req, 15);
        check_output("to_busy_end", {31'b0, busy}, 32'h0);

        // RUN blocks a WRITE; HALT lets the same WRITE through
        apply_stimulus(2'b11, 8'h00, 16'h0000, 1'b1, 12);
        check_output("run_on", {31'b0, cpu_run}, 32'h1);
        base_req = req_cnt;
        apply_stimulus(2'b01, 8'h10, 16'hFFFF, 1'b1, 28);
        check_output("rej_ferr", {31'b0, frame_err}, 32'h1);
        check_output("rej_req", {31'b0, mem_req}, 32'h0);
        step();
        check_output("rej_ferr_pulse", {31'b0, frame_err}, 32'h0);
        check_output("rej_req_cnt", req_cnt - base_req, 0);
        apply_stimulus(2'b00, 8'h00, 16'h0000, 1'b1, 12);
        check_output("halt_off", {31'b0, cpu_run}, 32'h0);
        apply_stimulus(2'b01, 8'h10, 16'hFFFF, 1'b1, 28);
        check_output("halt_wr_req", {31'b0, mem_req}, 32'h1);
        check_output("halt_wr_addr", {24'b0, mem_addr}, 32'h10);
        check_output("halt_wr_wdata", {16'b0, mem_wdata}, 32'hFFFF);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_output("halt_wr_drop", {31'b0, mem_req}, 32'h0);

        // Bad stop bit discards the frame; the next one executes
        base_req = req_cnt;
        apply_stimulus(2'b01, 8'h22, 16'h1357, 1'b0, 28);
        check_output("stop_ferr", {31'b0, frame_err}, 32'h1);
        check_output("stop_req", {31'b0, mem_req}, 32'h0);
        check_output("stop_busy", {31'b0, busy}, 32'h0);
        step();
        check_output("stop_req_cnt", req_cnt - base_req, 0);
        apply_stimulus(2'b01, 8'h22, 16'h1357, 1'b1, 28);
        check_output("stop_next_req", {31'b0, mem_req}, 32'h1);
        check_output("stop_next_wdata", {16'b0, mem_wdata}, 32'h1357);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;

        // Reset in the middle of the DATA field
        apply_stimulus(2'b11, 8'h00, 16'h0000, 1'b1, 12);
        base_req = req_cnt;
        apply_stimulus(2'b01, 8'h44, 16'hBEEF, 1'b1, 15);
        check_output("mid_busy", {31'b0, busy}, 32'h1);
        #2;
        RN = 1'b0;
        #1;
        check_output("rd_run_clr", {31'b0, cpu_run}, 32'h0);
        check_output("rd_busy_clr", {31'b0, busy}, 32'h0);
        check_output("rd_so_clr", {31'b0, so}, 32'h1);
        step();
        RN = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_output("rd_after_busy", {31'b0, busy}, 32'h0);
        check_output("rd_after_req", req_cnt - base_req, 0);

        // Reset while a request is outstanding
        apply_stimulus(2'b10, 8'h09, 16'h0000, 1'b1, 12);
        check_output("rx_req_up", {31'b0, mem_req}, 32'h1);
        #2;
        RN = 1'b0;
        #1;
        check_output("rx_req_clr", {31'b0, mem_req}, 32'h0);
        check_output("rx_addr_clr", {24'b0, mem_addr}, 32'h0);
        check_output("rx_wdata_clr", {16'b0, mem_wdata}, 32'h0);
        check_output("rx_busy_clr", {31'b0, busy}, 32'h0);
        step();
        RN = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_output("rx_after_req", req_cnt - base_req, 0);
        apply_stimulus(2'b01, 8'h5A, 16'h0F0F, 1'b1, 28);
        check_output("post_req", {31'b0, mem_req}, 32'h1);
        check_output("post_addr", {24'b0, mem_addr}, 32'h5A);
        check_output("post_wdata", {16'b0, mem_wdata}, 32'h0F0F);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_output("post_busy", {31'b0, busy}, 32'h0);
        step();

        check_output("ferr_total", ferr_cnt, 3);
        check_output("ferr_req_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_host_ctrl.md
Name: serial_host_ctrl

Overview:
- Single-pin serial host controller between the chip's serial input/output pads and the 16-bit CPU core.
- Deserialises host command frames from SI and sequences CPU memory writes and reads through a req/ack port.
- Serialises read data back on SO and gates the CPU run enable.
- Sits inside the pad-ring top, between the SI/SO pad cells and the CPU.

Parameters:
- DATA_W, 16, memory data width and response payload width.
- ADDR_W, 8, memory address field width.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting the access.

Ports:
- C  in  1  clock; all logic on rising edge.
- RN  in  1  reset, asynchronous assert, active-low.
- si  in  1  serial input, already synchronous to C; one bit sampled per cycle; idle high.
- so  out  1  serial output, one bit per cycle; idle high.
- cpu_run  out  1  CPU run enable.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  high whenever state != IDLE.
- frame_err  out  1  one-cycle error pulse.

Behaviour:
- Reset (RN=0, asynchronous): state=IDLE, so=1, cpu_run=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_err=0.
- Frame format, MSB first, one bit per cycle:
  - start bit 0
  - OP[1:0]
  - ADDR[ADDR_W-1:0]
  - DATA[DATA_W-1:0], WRITE only
  - stop bit 1
- Opcodes: 00 HALT, 01 WRITE, 10 READ, 11 RUN.
- State machine: IDLE -> OPC -> ADDR -> DATA (WRITE only) -> STOP -> EXEC -> RESP (READ only) -> IDLE.
- IDLE: si=0 moves to OPC in the next cycle; si=1 stays in IDLE.
- OPC, ADDR, DATA: bit counter counts down; shift register captures each bit. HALT and RUN still carry ADDR bits, which are ignored.
- STOP, si=0: frame_err pulse, command discarded, return to IDLE.
- STOP, si=1, HALT: cpu_run=0 next cycle, return to IDLE.
- STOP, si=1, RUN: cpu_run=1 next cycle, return to IDLE.
- STOP, si=1, WRITE/READ while cpu_run=1: rejected; frame_err pulse, return to IDLE.
- STOP, si=1, WRITE/READ while cpu_run=0: go to EXEC.
- EXEC:
  - mem_req=1 from the cycle after the stop bit is sampled; held with stable addr/we/wdata until mem_ack.
  - mem_ack is honoured in the first req cycle.
  - mem_req drops the cycle after ack.
  - WRITE then returns to IDLE; READ captures mem_rdata and goes to RESP.
- Timeout:
  - A counter runs in EXEC. If no ack after TIMEOUT req cycles: drop mem_req, pulse frame_err.
  - A timed-out WRITE returns to IDLE.
  - A timed-out READ responds with 16'hDEAD (low DATA_W bits of the pattern).
- RESP: so drives start bit 0, then DATA_W bits MSB first, then stop bit 1, then returns to IDLE. so is 1 at every other time.
- si is ignored in EXEC and RESP; the host must not start a frame until the response completes.
- Frame length: 28 cycles for WRITE, 12 cycles for READ/HALT/RUN (default widths). READ response: 18 cycles.
- Reset mid-frame or mid-access: immediate abort to reset values, mem_req drops asynchronously, no partial write.
- frame_err never overlaps mem_req.

Decomposition:
- Package serial_host_pkg: opcode constants (OP_HALT, OP_WRITE, OP_READ, OP_RUN), state enum, TIMEOUT_PATTERN constant.
- One natural sub-module, serial_tx_shift: a DATA_W+2 bit parallel-load shifter that drives so.
- FSM, receive shifter and counters stay in the top of the block.

Test Plan:
- WRITE addr 8'h3C data 16'hA55A, mem_ack in the first req cycle -> one-cycle mem_req with we=1, addr=3C, wdata=A55A, the cycle after the stop bit; busy low the next cycle.
- READ addr 8'h05, mem_ack 3 cycles after req with rdata 16'h1234 -> so = 0, 0001001000110100, 1, starting the cycle after ack; so=1 otherwise.
- READ addr 8'h07 with mem_ack never asserted -> mem_req high exactly 15 cycles, one frame_err pulse, so serialises 16'hDEAD.
- RUN frame, then WRITE 8'h10/16'hFFFF -> cpu_run=1; WRITE rejected with frame_err and no mem_req. HALT frame, then the same WRITE -> cpu_run=0 and the write is issued.
- WRITE frame with stop bit 0 -> frame_err pulse, no mem_req, return to IDLE; the next valid frame executes normally.
- RN low during DATA and again during EXEC with mem_req=1 -> all outputs at reset values immediately; no mem_req after RN rises; a subsequent frame executes normally.
